rx_chan_scheduler: RTL and testbench

- Per-packet scheduler for the inband RX path: chooses which RX channel FIFO the packet builder serves next, and when it serves it.
- Control/command channel (index NUM_CHAN) has strict priority. Data channels 0..NUM_CHAN-1 are served round-robin.
- A data channel becomes eligible at a full-payload watermark, or after an age timeout so that partial data is flushed.
- Drives the builder's start/channel-select handshake and keeps sticky per-channel overrun flags for the packet header.

---
 rtl/rx_chan_scheduler_if.sv | 32 +++
 rtl/rx_chan_scheduler.sv | 173 +++++++++++++++++
 tb/tb_rx_chan_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_chan_scheduler_if.sv
// Bundle between the RX channel scheduler, the channel FIFO status and the packet builder.
// Handshake: pkt_start is a one-cycle grant pulse with no back-pressure; pkt_done is a one-cycle reply that is honoured only while the scheduler waits for it.
interface rx_chan_scheduler_if #(
  parameter int NUM_CHAN = 4,
  parameter int USEDW_W  = 10
);
  logic                           enable;
  logic [(NUM_CHAN+1)*USEDW_W-1:0] chan_usedw;
  logic [NUM_CHAN:0]              chan_empty;
  logic                           have_space;
  logic                           pkt_done;
  logic                           pkt_start;
  logic [3:0]                     pkt_chan;
  logic                           pkt_short;
  logic                           busy;
  logic [NUM_CHAN:0]              overrun;
  logic [NUM_CHAN:0]              hdr_overrun;
  logic [(NUM_CHAN+1)*16-1:0]     grant_count;
  logic [1:0]                     state_dbg;

  modport master (
    input  enable, chan_usedw, chan_empty, have_space, pkt_done,
    output pkt_start, pkt_chan, pkt_short, busy, overrun, hdr_overrun,
           grant_count, state_dbg
  );

  modport slave (
    output enable, chan_usedw, chan_empty, have_space, pkt_done,
    input  pkt_start, pkt_chan, pkt_short, busy, overrun, hdr_overrun,
           grant_count, state_dbg
  );
endinterface

// File: rtl/rx_chan_scheduler.sv
// Per-packet RX channel scheduler: strict-priority control channel, round-robin data channels
// with watermark/age eligibility. Define RX_SCHED_STATS_EN to build per-channel grant counters.
module rx_chan_scheduler #(
  parameter int NUM_CHAN  = 4,
  parameter int USEDW_W   = 10,
  parameter int THRESHOLD = 504,
  parameter int AGE_MAX   = 4096
) (
  input  logic                rxclk,
  input  logic                reset,
  rx_chan_scheduler_if.master bus
);
  localparam int                 NC      = NUM_CHAN + 1;
  localparam logic [USEDW_W-1:0] THR     = USEDW_W'(THRESHOLD);
  localparam logic [15:0]        AGE_SAT = 16'(AGE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [USEDW_W-1:0]  usedw [NC];
  logic [NC-1:0]       ready;
  logic [NC-1:0]       overrun_q, hdr_overrun_q;
  logic [3:0]          rr_ptr, win_chan, pkt_chan_q;
  logic                win_found, win_short, grant;
  logic                pkt_start_q, pkt_short_q, busy_q;
  logic                hi_found, lo_found, hi_short, lo_short;
  logic [3:0]          hi_chan, lo_chan;

  for (genvar i = 0; i < NC; i++) begin : g_unpack
    assign usedw[i] = bus.chan_usedw[i*USEDW_W +: USEDW_W];
  end

  assign ready[NUM_CHAN] = ~bus.chan_empty[NUM_CHAN];

  // Age only runs on partial data; a full channel is already eligible and just holds its age.
  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_age
    logic [15:0] age_q;
    assign ready[i] = ~bus.chan_empty[i] && (usedw[i] >= THR || age_q == AGE_SAT);
    always_ff @(posedge rxclk) begin
      if (reset) begin
        age_q <= '0;
      end else if (bus.chan_empty[i] || (grant && win_chan == 4'(i))) begin
        age_q <= '0;
      end else if (usedw[i] < THR && age_q != AGE_SAT) begin
        age_q <= age_q + 16'd1;
      end
    end
  end

  // Round robin: hi_* is the lowest ready channel at or above rr_ptr, lo_* the lowest overall (wrap case).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_chan  = '0;
    lo_chan  = '0;
    hi_short = 1'b0;
    lo_short = 1'b0;
    for (int j = NUM_CHAN - 1; j >= 0; j--) begin
      if (ready[j]) begin
        lo_found = 1'b1;
        lo_chan  = 4'(j);
        lo_short = usedw[j] < THR;
        if (4'(j) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_chan  = 4'(j);
          hi_short = usedw[j] < THR;
        end
      end
    end
  end

  always_comb begin
    win_found = ready[NUM_CHAN] | lo_found;
    win_chan  = lo_chan;
    win_short = lo_short;
    if (ready[NUM_CHAN]) begin
      win_chan  = 4'(NUM_CHAN);
      win_short = usedw[NUM_CHAN] < THR;
    end else if (hi_found) begin
      win_chan  = hi_chan;
      win_short = hi_short;
    end
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && bus.have_space && win_found) begin
          grant    = 1'b1;
          state_nx = GRANT;
        end
      end
      GRANT:   state_nx = WAIT;
      WAIT:    if (bus.pkt_done) state_nx = HOLDOFF;
      HOLDOFF: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state         <= IDLE;
      pkt_start_q   <= 1'b0;
      pkt_chan_q    <= '0;
      pkt_short_q   <= 1'b0;
      busy_q        <= 1'b0;
      rr_ptr        <= '0;
      hdr_overrun_q <= '0;
    end else begin
      state       <= state_nx;
      pkt_start_q <= grant;
      if (grant) begin
        pkt_chan_q    <= win_chan;
        pkt_short_q   <= win_short;
        busy_q        <= 1'b1;
        hdr_overrun_q <= overrun_q;
        if (!ready[NUM_CHAN]) begin
          rr_ptr <= (win_chan == 4'(NUM_CHAN - 1)) ? 4'd0 : win_chan + 4'd1;
        end
      end else if (state == WAIT && bus.pkt_done) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Grant clear takes precedence over a same-edge overrun set on the granted channel.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      overrun_q <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (grant && win_chan == 4'(i)) begin
          overrun_q[i] <= 1'b0;
        end else if (ready[i] && !bus.have_space) begin
          overrun_q[i] <= 1'b1;
        end
      end
    end
  end

`ifdef RX_SCHED_STATS_EN
  logic [NC-1:0][15:0] gcnt_q;
  always_ff @(posedge rxclk) begin
    if (reset) begin
      gcnt_q <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (pkt_start_q && pkt_chan_q == 4'(i) && gcnt_q[i] != 16'hffff) begin
          gcnt_q[i] <= gcnt_q[i] + 16'd1;
        end
      end
    end
  end
  assign bus.grant_count = gcnt_q;
`else
  assign bus.grant_count = '0;
`endif

  assign bus.pkt_start   = pkt_start_q;
  assign bus.pkt_chan    = pkt_chan_q;
  assign bus.pkt_short   = pkt_short_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
  assign bus.hdr_overrun = hdr_overrun_q;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_rx_chan_scheduler.sv
// Directed bench for rx_chan_scheduler: expected grants are queued by the stimulus and
// compared by an independent monitor on every pkt_start pulse.
module tb_rx_chan_scheduler;
  localparam int NUM_CHAN = 4;
  localparam int USEDW_W  = 10;
  localparam int NC       = NUM_CHAN + 1;

  logic rxclk = 1'b0;
  logic reset = 1'b1;
  always #5 rxclk = ~rxclk;

  rx_chan_scheduler_if #(.NUM_CHAN(NUM_CHAN), .USEDW_W(USEDW_W)) bus ();

  rx_chan_scheduler #(
    .NUM_CHAN(NUM_CHAN), .USEDW_W(USEDW_W), .THRESHOLD(504), .AGE_MAX(4096)
  ) dut (
    .rxclk(rxclk),
    .reset(reset),
    .bus  (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] exp_q[$];  // {check_short, chan[3:0], short}

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_chan(input int ch, input int u, input bit e);
    bus.chan_usedw[ch*USEDW_W +: USEDW_W] = USEDW_W'(u);
    bus.chan_empty[ch] = e;
  endtask

  task automatic do_reset();
    bus.enable     = 1'b1;
    bus.have_space = 1'b1;
    bus.pkt_done   = 1'b0;
    bus.chan_usedw = '0;
    bus.chan_empty = '1;
    reset = 1'b1;
    repeat (2) @(negedge rxclk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int ch, input bit sh, input bit care, input int lat, input int max_cyc);
    int cyc;
    cyc = 0;
    exp_q.push_back({care, 4'(ch), sh});
    do begin
      @(negedge rxclk);
      cyc++;
    end while (bus.pkt_start !== 1'b1 && cyc < max_cyc);
    if (bus.pkt_start !== 1'b1) begin
      check("grant_timeout", 80'(cyc), 80'(0));
      void'(exp_q.pop_back());
    end else if (lat != 0) begin
      check("grant_latency", 80'(cyc), 80'(lat));
    end
  endtask

  task automatic finish_pkt(input int ch, input bit drain);
    if (drain) set_chan(ch, 0, 1'b1);
    @(negedge rxclk);
    bus.pkt_done = 1'b1;
    @(negedge rxclk);
    bus.pkt_done = 1'b0;
  endtask

  task automatic count_idle(input string name, input int cycles);
    int starts;
    starts = 0;
    repeat (cycles) begin
      @(negedge rxclk);
      if (bus.pkt_start === 1'b1) starts++;
    end
    check(name, 80'(starts), 80'(0));
  endtask

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(negedge rxclk);
      if (bus.pkt_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 80'(1), 80'(0));
        end else begin
          e = exp_q.pop_front();
          check("grant_chan", 80'(bus.pkt_chan), 80'(e[4:1]));
          if (e[5]) check("grant_short", 80'(bus.pkt_short), 80'(e[0]));
        end
      end
    end
  end

  initial begin : stimulus
    logic [79:0] exp_cnt;

    // Reset state and a single full-payload grant on channel 1.
    do_reset();
    check("rst_start", 80'(bus.pkt_start), 80'(0));
    check("rst_chan", 80'(bus.pkt_chan), 80'(0));
    check("rst_short", 80'(bus.pkt_short), 80'(0));
    check("rst_busy", 80'(bus.busy), 80'(0));
    check("rst_overrun", 80'(bus.overrun), 80'(0));
    check("rst_state", 80'(bus.state_dbg), 80'(0));
    check("rst_gcount", bus.grant_count, 80'(0));
    set_chan(1, 504, 1'b0);
    wait_grant(1, 1'b0, 1'b1, 1, 20);
    check("t1_busy_grant", 80'(bus.busy), 80'(1));
    check("t1_state_grant", 80'(bus.state_dbg), 80'(1));
    set_chan(1, 0, 1'b1);
    @(negedge rxclk);
    check("t1_start_pulse", 80'(bus.pkt_start), 80'(0));
    check("t1_state_wait", 80'(bus.state_dbg), 80'(2));
    check("t1_busy_wait", 80'(bus.busy), 80'(1));
    bus.pkt_done = 1'b1;
    @(negedge rxclk);
    bus.pkt_done = 1'b0;
    check("t1_state_holdoff", 80'(bus.state_dbg), 80'(3));
    check("t1_busy_done", 80'(bus.busy), 80'(0));
    @(negedge rxclk);
    check("t1_state_idle", 80'(bus.state_dbg), 80'(0));
    check("t1_chan_stable", 80'(bus.pkt_chan), 80'(1));

    // Round robin over channels 0, 2, 3, then all four ready.
    do_reset();
    set_chan(0, 504, 1'b0);
    set_chan(2, 504, 1'b0);
    set_chan(3, 504, 1'b0);
    wait_grant(0, 1'b0, 1'b1, 1, 20);  finish_pkt(0, 1'b1);
    wait_grant(2, 1'b0, 1'b1, 2, 20);  finish_pkt(2, 1'b1);
    wait_grant(3, 1'b0, 1'b1, 2, 20);  finish_pkt(3, 1'b1);
    for (int c = 0; c < NUM_CHAN; c++) set_chan(c, 504, 1'b0);
    for (int c = 0; c < NUM_CHAN; c++) begin
      wait_grant(c, 1'b0, 1'b1, 2, 20);
      finish_pkt(c, 1'b1);
    end

    // Control channel beats a ready data channel.
    do_reset();
    set_chan(NUM_CHAN, 8, 1'b0);
    set_chan(0, 504, 1'b0);
    wait_grant(NUM_CHAN, 1'b1, 1'b0, 1, 20);  finish_pkt(NUM_CHAN, 1'b1);
    wait_grant(0, 1'b0, 1'b1, 2, 20);         finish_pkt(0, 1'b1);

    // Age flush of a partial channel, then age restarts after the grant.
    do_reset();
    set_chan(2, 10, 1'b0);
    wait_grant(2, 1'b1, 1'b1, 4097, 5000);
    finish_pkt(2, 1'b0);
    count_idle("t4_age_cleared", 100);
    set_chan(2, 0, 1'b1);

    // Overrun set while there is no space, cleared by the grant, shadowed into the header.
    do_reset();
    bus.have_space = 1'b0;
    set_chan(3, 504, 1'b0);
    repeat (5) @(negedge rxclk);
    check("t5_overrun_set", 80'(bus.overrun), 80'(5'b01000));
    check("t5_no_grant", 80'(bus.state_dbg), 80'(0));
    bus.have_space = 1'b1;
    wait_grant(3, 1'b0, 1'b1, 1, 20);
    check("t5_overrun_clr", 80'(bus.overrun), 80'(0));
    check("t5_hdr_overrun", 80'(bus.hdr_overrun), 80'(5'b01000));
    finish_pkt(3, 1'b1);

    // Reset during WAIT, followed by a stale pkt_done.
    do_reset();
    set_chan(1, 504, 1'b0);
    wait_grant(1, 1'b0, 1'b1, 1, 20);
    set_chan(1, 0, 1'b1);
    @(negedge rxclk);
    check("t6_state_wait", 80'(bus.state_dbg), 80'(2));
`ifdef RX_SCHED_STATS_EN
    exp_cnt = 80'(1) << 16;
`else
    exp_cnt = '0;
`endif
    check("t6_gcount", bus.grant_count, exp_cnt);
    reset = 1'b1;
    @(negedge rxclk);
    reset = 1'b0;
    bus.pkt_done = 1'b1;
    check("t6_rst_start", 80'(bus.pkt_start), 80'(0));
    check("t6_rst_busy", 80'(bus.busy), 80'(0));
    check("t6_rst_chan", 80'(bus.pkt_chan), 80'(0));
    check("t6_rst_state", 80'(bus.state_dbg), 80'(0));
    check("t6_rst_gcount", bus.grant_count, 80'(0));
    @(negedge rxclk);
    bus.pkt_done = 1'b0;
    check("t6_done_ignored", 80'(bus.state_dbg), 80'(0));
    count_idle("t6_no_grant", 20);
    set_chan(1, 504, 1'b0);
    wait_grant(1, 1'b0, 1'b1, 1, 20);
    finish_pkt(1, 1'b1);
    repeat (4) @(negedge rxclk);

    check("queue_empty", 80'(exp_q.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
